// File: rtl/multi_issue_inst_fifo_pkg.sv
// Shared defaults for the fetch-to-decode instruction queue.
package multi_issue_inst_fifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ENQ_W  = 2;
  localparam int DEF_DEQ_W  = 2;
endpackage

// File: rtl/multi_issue_inst_fifo_if.sv
// Fetch/decode-facing bundle of the instruction queue; master drives enqueue data and dequeue ready.
interface multi_issue_inst_fifo_if
  import multi_issue_inst_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ENQ_W  = DEF_ENQ_W,
  parameter int DEQ_W  = DEF_DEQ_W,
  localparam int PTR_W = $clog2(DEPTH)
);
  logic                    flush;
  logic [ENQ_W-1:0]        enq_valid;
  logic [ENQ_W*DATA_W-1:0] enq_inst;
  logic [ENQ_W*DATA_W-1:0] enq_pc;
  logic                    enq_ready;
  logic [DEQ_W-1:0]        deq_valid;
  logic [DEQ_W*DATA_W-1:0] deq_inst;
  logic [DEQ_W*DATA_W-1:0] deq_pc;
  logic [DEQ_W-1:0]        deq_ready;
  logic [PTR_W:0]          count;
  logic                    full;
  logic                    empty;

  modport master (
    output flush, enq_valid, enq_inst, enq_pc, deq_ready,
    input  enq_ready, deq_valid, deq_inst, deq_pc, count, full, empty
  );

  modport slave (
    input  flush, enq_valid, enq_inst, enq_pc, deq_ready,
    output enq_ready, deq_valid, deq_inst, deq_pc, count, full, empty
  );
endinterface

// File: rtl/multi_issue_inst_fifo_lane_compact.sv
// Maps sparse enqueue lane valids to dense write offsets (exclusive prefix count) and a total.
module ifq_lane_compact
  import multi_issue_inst_fifo_pkg::*;
#(
  parameter int ENQ_W = DEF_ENQ_W,
  localparam int OFF_W = $clog2(ENQ_W + 1)
) (
  input  logic [ENQ_W-1:0]            valid,
  output logic [ENQ_W-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]            n
);
  logic [OFF_W-1:0] acc_s;

  // Running count of valid lanes below each lane gives its slot after tail
  always_comb begin
    acc_s  = {OFF_W{1'b0}};
    offset = {ENQ_W*OFF_W{1'b0}};
    for (int i = 0; i < ENQ_W; i++) begin
      offset[i] = acc_s;
      if (valid[i]) begin
        acc_s = acc_s + OFF_W'(1);
      end else begin
        acc_s = acc_s;
      end
    end
    n = acc_s;
  end
endmodule

// File: rtl/multi_issue_inst_fifo.sv
// Multi-lane instruction/PC queue between fetch and decode with fall-through dequeue and flush.
module multi_issue_inst_fifo
  import multi_issue_inst_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ENQ_W  = DEF_ENQ_W,
  parameter int DEQ_W  = DEF_DEQ_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  multi_issue_inst_fifo_if.slave bus
);
  localparam int OFF_W = $clog2(ENQ_W + 1);
  localparam int M_W   = $clog2(DEQ_W + 1);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]          inst_mem_r [DEPTH];
  logic [DATA_W-1:0]          pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]           head_r;
  logic [PTR_W-1:0]           tail_r;
  logic [CNT_W-1:0]           count_r;
  logic [ENQ_W-1:0][OFF_W-1:0] off_s;
  logic [OFF_W-1:0]           n_s;
  logic [OFF_W-1:0]           n_fire_s;
  logic                       enq_ready_s;
  logic                       fire_s;
  logic [DEQ_W-1:0]           deq_valid_s;
  logic [M_W-1:0]             m_s;
  logic                       run_s;
  logic [PTR_W-1:0]           rd_idx_s;

  ifq_lane_compact #(.ENQ_W(ENQ_W)) u_compact (
    .valid  (bus.enq_valid),
    .offset (off_s),
    .n      (n_s)
  );

  // Enqueue credit comes from registered occupancy only, never from same-cycle dequeue
  always_comb begin
    enq_ready_s   = ((CNT_W'(DEPTH) - count_r) >= CNT_W'(ENQ_W));
    fire_s        = enq_ready_s & (|bus.enq_valid);
    n_fire_s      = fire_s ? n_s : {OFF_W{1'b0}};
    bus.enq_ready = enq_ready_s;
    bus.count     = count_r;
    bus.full      = (count_r == CNT_W'(DEPTH));
    bus.empty     = (count_r == {CNT_W{1'b0}});
  end

  // Fall-through read of the oldest entries plus in-order leading-ones accept count
  always_comb begin
    bus.deq_inst = {DEQ_W*DATA_W{1'b0}};
    bus.deq_pc   = {DEQ_W*DATA_W{1'b0}};
    deq_valid_s  = {DEQ_W{1'b0}};
    rd_idx_s     = head_r;
    m_s          = {M_W{1'b0}};
    run_s        = 1'b1;
    for (int i = 0; i < DEQ_W; i++) begin
      rd_idx_s       = head_r + PTR_W'(i);
      deq_valid_s[i] = (count_r > CNT_W'(i));
      if (deq_valid_s[i]) begin
        bus.deq_inst[i*DATA_W +: DATA_W] = inst_mem_r[rd_idx_s];
        bus.deq_pc[i*DATA_W +: DATA_W]   = pc_mem_r[rd_idx_s];
      end else begin
        bus.deq_inst[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        bus.deq_pc[i*DATA_W +: DATA_W]   = {DATA_W{1'b0}};
      end
      // Once a lane is not taken, younger lanes cannot issue this cycle
      if (run_s && deq_valid_s[i] && bus.deq_ready[i]) begin
        m_s = m_s + M_W'(1);
      end else begin
        run_s = 1'b0;
      end
    end
    bus.deq_valid = deq_valid_s;
  end

  // Storage write of compacted lanes; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && fire_s) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (bus.enq_valid[i]) begin
          inst_mem_r[tail_r + PTR_W'(off_s[i])] <= bus.enq_inst[i*DATA_W +: DATA_W];
          pc_mem_r[tail_r + PTR_W'(off_s[i])]   <= bus.enq_pc[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pointer and occupancy update; flush empties the queue exactly like reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      tail_r  <= tail_r + PTR_W'(n_fire_s);
      head_r  <= head_r + PTR_W'(m_s);
      count_r <= count_r + CNT_W'(n_fire_s) - CNT_W'(m_s);
    end
  end
endmodule

// File: tb/tb_multi_issue_inst_fifo.sv
// Directed bench for multi_issue_inst_fifo with a reference queue scoring every accepted lane.
module tb_multi_issue_inst_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ENQ_W  = 2;
  localparam int DEQ_W  = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [63:0] model_q [$];

  always #5 clk = ~clk;

  multi_issue_inst_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) ifc ();

  multi_issue_inst_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic set_idle();
    ifc.flush     = 1'b0;
    ifc.enq_valid = 2'b00;
    ifc.enq_inst  = 64'h0;
    ifc.enq_pc    = 64'h0;
    ifc.deq_ready = 2'b00;
  endtask

  // One clock of traffic; scoreboard-checks handshake, every accepted lane and resulting occupancy
  task automatic drive_cycle(input logic fl, input logic [1:0] ev, input logic [31:0] pc0,
                             input logic [31:0] pc1, input logic [1:0] dr);
    logic       exp_rdy;
    logic [1:0] exp_dv;
    int         m;
    bit         run;
    logic [31:0] pcs [2];
    pcs[0] = pc0;
    pcs[1] = pc1;
    ifc.flush     = fl;
    ifc.enq_valid = ev;
    ifc.enq_pc    = {pc1, pc0};
    ifc.enq_inst  = {mk_inst(pc1), mk_inst(pc0)};
    ifc.deq_ready = dr;
    #1;
    exp_rdy = (DEPTH - model_q.size()) >= ENQ_W;
    exp_dv  = {model_q.size() > 1, model_q.size() > 0};
    n_checks++;
    if (ifc.enq_ready !== exp_rdy) $display("FAIL enq_ready: got %b want %b", ifc.enq_ready, exp_rdy);
    else n_pass++;
    n_checks++;
    if (ifc.deq_valid !== exp_dv) $display("FAIL deq_valid: got %b want %b", ifc.deq_valid, exp_dv);
    else n_pass++;
    m   = 0;
    run = 1'b1;
    for (int i = 0; i < DEQ_W; i++) begin
      if (!exp_dv[i]) begin
        n_checks++;
        if (ifc.deq_pc[i*32 +: 32] !== 32'h0 || ifc.deq_inst[i*32 +: 32] !== 32'h0)
          $display("FAIL idle_lane%0d: got pc %h inst %h want 0", i, ifc.deq_pc[i*32 +: 32], ifc.deq_inst[i*32 +: 32]);
        else n_pass++;
      end
      if (run && exp_dv[i] && dr[i]) begin
        n_checks++;
        if (ifc.deq_pc[i*32 +: 32] !== model_q[i][31:0] || ifc.deq_inst[i*32 +: 32] !== model_q[i][63:32])
          $display("FAIL sb_lane%0d: got pc %h inst %h want pc %h inst %h", i, ifc.deq_pc[i*32 +: 32],
                   ifc.deq_inst[i*32 +: 32], model_q[i][31:0], model_q[i][63:32]);
        else n_pass++;
        m++;
      end else begin
        run = 1'b0;
      end
    end
    if (fl) begin
      model_q.delete();
    end else begin
      repeat (m) void'(model_q.pop_front());
      if (exp_rdy) begin
        for (int i = 0; i < ENQ_W; i++) if (ev[i]) model_q.push_back({mk_inst(pcs[i]), pcs[i]});
      end
    end
    @(posedge clk);
    #1;
    set_idle();
    n_checks++;
    if (ifc.count !== 6'(model_q.size()) || ifc.empty !== (model_q.size() == 0) ||
        ifc.full !== (model_q.size() == DEPTH))
      $display("FAIL occupancy: got count %0d full %b empty %b want count %0d", ifc.count, ifc.full,
               ifc.empty, model_q.size());
    else n_pass++;
  endtask

  task automatic drain();
    while (model_q.size() > 0) drive_cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ifc.count !== 6'd0 || ifc.empty !== 1'b1 || ifc.full !== 1'b0 || ifc.enq_ready !== 1'b1)
      $display("FAIL reset_status: got count %0d empty %b full %b rdy %b want 0 1 0 1", ifc.count,
               ifc.empty, ifc.full, ifc.enq_ready);
    else n_pass++;
    n_checks++;
    if (ifc.deq_valid !== 2'b00 || ifc.deq_inst !== 64'h0 || ifc.deq_pc !== 64'h0)
      $display("FAIL reset_deq: got valid %b inst %h pc %h want 0", ifc.deq_valid, ifc.deq_inst, ifc.deq_pc);
    else n_pass++;
    rst = 1'b1;
    model_q.delete();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 16; k++)
      drive_cycle(1'b0, 2'b11, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 2'b00);
    n_checks++;
    if (ifc.count !== 6'd32 || ifc.full !== 1'b1 || ifc.enq_ready !== 1'b0)
      $display("FAIL fill_full: got count %0d full %b rdy %b want 32 1 0", ifc.count, ifc.full, ifc.enq_ready);
    else n_pass++;
    drive_cycle(1'b0, 2'b11, 32'hBAD0, 32'hBAD4, 2'b00);
    n_checks++;
    if (ifc.count !== 6'd32) $display("FAIL fill_drop: got count %0d want 32", ifc.count);
    else n_pass++;
    drain();
  endtask

  task automatic test_compaction();
    drive_cycle(1'b0, 2'b10, 32'hDEAD, 32'h100, 2'b00);
    drive_cycle(1'b0, 2'b11, 32'h104, 32'h108, 2'b00);
    n_checks++;
    if (ifc.deq_pc[31:0] !== 32'h100 || ifc.deq_pc[63:32] !== 32'h104 || ifc.count !== 6'd3)
      $display("FAIL compaction: got pc0 %h pc1 %h count %0d want 100 104 3", ifc.deq_pc[31:0],
               ifc.deq_pc[63:32], ifc.count);
    else n_pass++;
  endtask

  task automatic test_partial_ready();
    drive_cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
    n_checks++;
    if (ifc.count !== 6'd3 || ifc.deq_pc[31:0] !== 32'h100)
      $display("FAIL nonprefix_ready: got count %0d pc0 %h want 3 100", ifc.count, ifc.deq_pc[31:0]);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    n_checks++;
    if (ifc.count !== 6'd2 || ifc.deq_pc[31:0] !== 32'h104)
      $display("FAIL prefix_ready: got count %0d pc0 %h want 2 104", ifc.count, ifc.deq_pc[31:0]);
    else n_pass++;
    drain();
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    for (int k = 0; k < 31; k++) begin
      drive_cycle(1'b0, 2'b01, 32'h2000 + 32'(4*k), 32'h0, 2'b00);
      drive_cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    end
    drive_cycle(1'b0, 2'b11, 32'h200, 32'h204, 2'b00);
    n_checks++;
    if (ifc.count !== 6'd2 || ifc.deq_pc[31:0] !== 32'h200 || ifc.deq_pc[63:32] !== 32'h204)
      $display("FAIL wrap_order: got count %0d pc0 %h pc1 %h want 2 200 204", ifc.count,
               ifc.deq_pc[31:0], ifc.deq_pc[63:32]);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    n_checks++;
    if (ifc.count !== 6'd0) $display("FAIL wrap_pop: got count %0d want 0", ifc.count);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive_cycle(1'b0, 2'b11, 32'h3000, 32'h3004, 2'b00);
    drive_cycle(1'b0, 2'b11, 32'h3008, 32'h300C, 2'b00);
    drive_cycle(1'b0, 2'b11, 32'h3010, 32'h3014, 2'b00);
    drive_cycle(1'b0, 2'b01, 32'h3018, 32'h0, 2'b00);
    n_checks++;
    if (ifc.count !== 6'd7) $display("FAIL flush_setup: got count %0d want 7", ifc.count);
    else n_pass++;
    drive_cycle(1'b1, 2'b11, 32'h3020, 32'h3024, 2'b11);
    n_checks++;
    if (ifc.count !== 6'd0 || ifc.deq_valid !== 2'b00 || ifc.empty !== 1'b1)
      $display("FAIL flush_clear: got count %0d valid %b empty %b want 0 00 1", ifc.count,
               ifc.deq_valid, ifc.empty);
    else n_pass++;
    drive_cycle(1'b0, 2'b01, 32'h300, 32'h0, 2'b00);
    n_checks++;
    if (ifc.deq_valid !== 2'b01 || ifc.deq_pc[31:0] !== 32'h300)
      $display("FAIL flush_refill: got valid %b pc0 %h want 01 300", ifc.deq_valid, ifc.deq_pc[31:0]);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ev_t [6] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] dr_t [6] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b11};
    for (int k = 0; k < 6; k++)
      drive_cycle(1'b0, ev_t[k], 32'h400 + 32'(8*k), 32'h404 + 32'(8*k), dr_t[k]);
    n_checks++;
    if (ifc.count !== 6'd0 || ifc.empty !== 1'b1)
      $display("FAIL b2b_end: got count %0d empty %b want 0 1", ifc.count, ifc.empty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_compaction();
    test_partial_ready();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
